walk_request: RTL and testbench
===============================

# walk_request

Pedestrian push-button front end for the traffic-light controller. Synchronizes and debounces the raw board button, detects a clean press, and holds a `Walk` request level into the controller until the controller acknowledges service. A press that arrives while a request is pending or being served does not queue. The held button must be released before a new request is accepted.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a button level change. Set to 500000 on the board. Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width. Derived; do not override.

Ports:
- `Clk`  in  1  system clock; one clock domain.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Button_raw`  in  1  raw push-button, active-high, asynchronous to `Clk`, bouncy.
- `Ack`  in  1  single-cycle pulse from the controller when it begins servicing a walk (enters RED).
- `Walk`  out  1  registered request level to the controller.
- `Button_db`  out  1  registered debounced button level.
- `Press`  out  1  one-cycle pulse on the rising edge of `Button_db`.

## Operation
- **Synchronizer:** two flops, `Button_raw` → `sync1` → `sync2`. Both reset to 0.
- **Debounce:**
  - On each edge where `sync2 != Button_db`, the counter increments.
  - On the edge where the counter equals `DEBOUNCE_CYCLES-1` and a mismatch still holds, `Button_db` toggles and the counter clears.
  - Any edge with `sync2 == Button_db` clears the counter, so a bounce restarts the count.
  - Release is debounced identically.
- **Edge detect:** `Press = Button_db & ~db_prev`, where `db_prev` is `Button_db` delayed one cycle. `Press` is high exactly one cycle per accepted press.
- **Request FSM:**
  - States: IDLE, PENDING, SERVED.
  - IDLE: `Press` → PENDING.
  - PENDING: `Ack` → SERVED. `Press` is ignored.
  - SERVED: `Button_db == 0` → IDLE. `Press` and `Ack` are ignored.
  - `Walk` = 1 only in PENDING; it is a registered output.
- **Simultaneous events:**
  - `Press` and `Ack` in the same cycle in IDLE → PENDING. A stray `Ack` in IDLE is ignored.
  - `Ack` and button release in the same cycle in PENDING → SERVED. The next cycle sees `Button_db == 0` and moves to IDLE.
- **Reset values:** `Walk`=0, `Button_db`=0, `Press`=0, counter=0, state=IDLE. Reset mid-operation drops `Walk` immediately (asynchronous).
- **Button held across reset release:** treated as a new press after the full debounce delay.

## Timing
- `Button_raw` goes high and stays stable before edge 1:
  - `sync2`=1 after edge 2.
  - Mismatch is counted on edges 3 through 2+`DEBOUNCE_CYCLES`.
  - `Button_db`=1 and `Press`=1 after edge 2+`DEBOUNCE_CYCLES`.
  - `Walk`=1 after edge 3+`DEBOUNCE_CYCLES`.
  - With the default of 16: `Button_db` at edge 18, `Walk` at edge 19.
- `Ack` sampled high on edge n in PENDING → `Walk`=0 after edge n.
- Release latency mirrors press latency: `Button_db` falls 2+`DEBOUNCE_CYCLES` edges after a stable low.
- No combinational path from any input to any output except `Press`, which is derived only from registers.

## Structure
- **Shared package** `traffic_pkg`:
  - enum `walk_state_t` {IDLE, PENDING, SERVED}, `logic [1:0]`.
  - constant `WALK_DEBOUNCE_SIM` = 16.
  - constant `WALK_DEBOUNCE_BOARD` = 500000.
- **Sub-module** `button_debounce`:
  - Contains the synchronizer and debounce counter.
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports: `Clk`, `Reset_n`, `In_raw`, `Out_db`.
- **Top** `walk_request`: edge detect and request FSM.

## Test plan
1. **Clean press:** `Button_raw` 0→1 before edge 1, held (default params) → `Button_db`/`Press` at edge 18, `Press` width 1 cycle, `Walk`=1 from edge 19. Then pulse `Ack` → `Walk`=0 the next cycle.
2. **Bounce rejection:** toggle `Button_raw` every 5 cycles for 60 cycles → `Button_db`, `Press` and `Walk` stay 0. Then hold high → `Walk` after the full delay, counted from the last edge.
3. **Held button, no re-request:** press, `Ack`, keep holding 100 cycles → `Walk` stays 0, state SERVED. Release, wait 18+ cycles, press again → `Walk` re-asserts.
4. **Press while pending:**
   - Press, release, press again before `Ack` → exactly one `Walk` assertion.
   - A single `Ack` clears it.
   - A second `Ack` in IDLE has no effect.
5. **Simultaneous:** force `Ack` high in the same cycle `Press` fires → `Walk`=1 next cycle, state PENDING.
6. **Reset mid-request:** `Walk`=1, assert `Reset_n`=0 between edges → `Walk`=0 immediately. Button still held at reset release → `Walk` after edge 3+`DEBOUNCE_CYCLES` counted from release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller blocks.
// Walk request FSM states and debounce lengths for simulation and board.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVED  = 2'd2
    } walk_state_t;

    localparam int WALK_DEBOUNCE_SIM   = 16;
    localparam int WALK_DEBOUNCE_BOARD = 500000;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The output level flips only after DEBOUNCE_CYCLES consecutive mismatches.
module button_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = WALK_DEBOUNCE_SIM,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic In_raw,
    output logic Out_db
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            Out_db <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= In_raw;
            sync2 <= sync1;
            // any agreeing sample restarts the count, so bounces never accumulate
            if (sync2 == Out_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                Out_db <= ~Out_db;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/walk_request.sv
// Pedestrian button front end: debounce, press edge detect and a
// request FSM that holds Walk until the controller acknowledges service.
module walk_request
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = WALK_DEBOUNCE_SIM,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Button_raw,
    input  logic Ack,
    output logic Walk,
    output logic Button_db,
    output logic Press
);

    walk_state_t state_q;
    walk_state_t state_d;
    logic        db_prev;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .In_raw (Button_raw),
        .Out_db (Button_db)
    );

    assign Press = Button_db & ~db_prev;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Press)      state_d = PENDING;
            PENDING: if (Ack)        state_d = SERVED;
            // wait for release so a held button cannot re-request
            SERVED:  if (!Button_db) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            db_prev <= 1'b0;
            Walk    <= 1'b0;
        end else begin
            state_q <= state_d;
            db_prev <= Button_db;
            Walk    <= (state_d == PENDING);
        end
    end

endmodule

// File: tb/tb_walk_request.sv
// Self-checking bench for walk_request: vector table, directed corner
// sequences and randomized button/ack traffic against a window model.
module tb_walk_request;

    localparam int DC = 16;

    logic Clk = 1'b0;
    logic Reset_n;
    logic Button_raw;
    logic Ack;
    logic Walk;
    logic Button_db;
    logic Press;

    always #5 Clk = ~Clk;

    walk_request #(.DEBOUNCE_CYCLES(DC)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Button_raw(Button_raw),
        .Ack       (Ack),
        .Walk      (Walk),
        .Button_db (Button_db),
        .Press     (Press)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    endtask

    // Reference: db flips once the last DC synchronized samples all
    // disagree with it and no flip happened inside that window.
    int hist[$];
    int win[$];
    bit m_db;
    bit m_press;
    bit m_walk;
    int m_state;
    int m_t;
    int m_last;

    task automatic model_reset();
        hist.delete();
        win.delete();
        m_db = 0;
        m_press = 0;
        m_walk = 0;
        m_state = 0;
        m_t = 0;
        m_last = -1000;
    endtask

    task automatic model_edge(input bit raw, input bit ack);
        int s2;
        bit db_pre;
        bit flip;
        m_t++;
        s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
        hist.push_back(int'(raw));
        if (hist.size() > 4) void'(hist.pop_front());
        win.push_back(s2);
        if (win.size() > DC) void'(win.pop_front());
        db_pre = m_db;
        flip = (win.size() == DC) && (m_t - m_last >= DC);
        foreach (win[i]) if (win[i] == int'(db_pre)) flip = 0;
        if (flip) begin
            m_db = ~m_db;
            m_last = m_t;
        end
        case (m_state)
            0: if (m_press) m_state = 1;
            1: if (ack) m_state = 2;
            default: if (!db_pre) m_state = 0;
        endcase
        m_press = m_db & ~db_pre;
        m_walk = (m_state == 1);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge(Button_raw, Ack);
        @(negedge Clk);
        check("model_db", Button_db, m_db);
        check("model_press", Press, m_press);
        check("model_walk", Walk, m_walk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        Button_raw = 1'b0;
        Ack = 1'b0;
        model_reset();
        #2;
        check("rst_walk", Walk, 1'b0);
        check("rst_db", Button_db, 1'b0);
        check("rst_press", Press, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    typedef struct {
        int n;
        bit raw;
        bit ack;
        bit db;
        bit press;
        bit walk;
    } vec_t;

    vec_t vt[12];

    initial begin
        int rises;
        bit pw;
        Reset_n = 1'b0;
        Button_raw = 1'b0;
        Ack = 1'b0;
        model_reset();

        // clean press, ack, long hold, release, re-press
        vt[0]  = '{17, 1, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 0, 1, 1, 0};
        vt[2]  = '{1, 1, 0, 1, 0, 1};
        vt[3]  = '{1, 1, 1, 1, 0, 0};
        vt[4]  = '{100, 1, 0, 1, 0, 0};
        vt[5]  = '{17, 0, 0, 1, 0, 0};
        vt[6]  = '{1, 0, 0, 0, 0, 0};
        vt[7]  = '{3, 0, 0, 0, 0, 0};
        vt[8]  = '{17, 1, 0, 0, 0, 0};
        vt[9]  = '{1, 1, 0, 1, 1, 0};
        vt[10] = '{1, 1, 0, 1, 0, 1};
        vt[11] = '{1, 1, 1, 1, 0, 0};

        do_reset();
        foreach (vt[i]) begin
            Button_raw = vt[i].raw;
            Ack = vt[i].ack;
            repeat (vt[i].n) tick();
            Ack = 1'b0;
            check($sformatf("vec%0d_db", i), Button_db, vt[i].db);
            check($sformatf("vec%0d_press", i), Press, vt[i].press);
            check($sformatf("vec%0d_walk", i), Walk, vt[i].walk);
        end

        // bounce rejection, then a stable press timed from the last edge
        do_reset();
        pw = 0;
        for (int i = 0; i < 60; i++) begin
            Button_raw = ((i / 5) % 2 == 0);
            tick();
            if (Button_db || Walk || Press) pw = 1;
        end
        check("bounce_quiet", pw, 1'b0);
        Button_raw = 1'b1;
        repeat (17) tick();
        check("bounce_db_early", Button_db, 1'b0);
        tick();
        check("bounce_db", Button_db, 1'b1);
        check("bounce_press", Press, 1'b1);
        tick();
        check("bounce_walk", Walk, 1'b1);

        // second press while pending does not re-request
        do_reset();
        rises = 0;
        pw = 0;
        Button_raw = 1'b1;
        for (int i = 0; i < 58; i++) begin
            if (i == 19) Button_raw = 1'b0;
            if (i == 39) Button_raw = 1'b1;
            tick();
            if (Walk && !pw) rises++;
            pw = Walk;
        end
        check("pend_walk_held", Walk, 1'b1);
        check("pend_one_rise", (rises == 1), 1'b1);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check("pend_ack_clears", Walk, 1'b0);
        Button_raw = 1'b0;
        repeat (22) tick();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        repeat (3) tick();
        check("idle_stray_ack", Walk, 1'b0);

        // press and ack in the same cycle
        do_reset();
        Button_raw = 1'b1;
        repeat (18) tick();
        check("simul_press", Press, 1'b1);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check("simul_walk", Walk, 1'b1);
        tick();
        check("simul_walk_hold", Walk, 1'b1);

        // asynchronous reset drops Walk; held button re-requests after release
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_walk", Walk, 1'b0);
        check("async_rst_db", Button_db, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (18) tick();
        check("held_rst_walk_early", Walk, 1'b0);
        tick();
        check("held_rst_walk", Walk, 1'b1);

        // randomized traffic against the model
        do_reset();
        for (int s = 0; s < 45; s++) begin
            Button_raw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 45)) begin
                Ack = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        Ack = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
